ram_port_arbiter: RTL

//  Shares one single-port synchronous RAM (1024 x 32, 1-cycle registered read) between two requesters.

---
 rtl/ram_ctrl_pkg.sv | 19 +
 rtl/ram_port_arbiter_rr_arb2.sv | 41 ++++
 rtl/ram_port_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizes for the RAM port arbiter.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Tag travelling alongside a RAM access so the read data can be routed back.
  typedef struct packed {
    logic id;
    logic rd;
  } rsp_tag_t;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: purely combinational grant plus next pointer.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_en,
  input  logic       i_ptr,
  output logic [1:0] o_grant,
  output logic       o_ptr_next
);

  // Grant the lone requester, or the favoured one on contention; favour the other next time.
  always_comb begin
    o_grant    = 2'b00;
    o_ptr_next = i_ptr;
    if (i_en) begin
      case (i_valid)
        2'b01: begin
          o_grant    = 2'b01;
          o_ptr_next = 1'b1;
        end
        2'b10: begin
          o_grant    = 2'b10;
          o_ptr_next = 1'b0;
        end
        2'b11: begin
          if (i_ptr) begin
            o_grant    = 2'b10;
            o_ptr_next = 1'b0;
          end else begin
            o_grant    = 2'b01;
            o_ptr_next = 1'b1;
          end
        end
        default: begin
          o_grant    = 2'b00;
          o_ptr_next = i_ptr;
        end
      endcase
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between two requesters, with a zeroing sweep
// after reset or on demand. Reads return two cycles after accept, tagged per requester.
//
// state    | meaning
// ST_CLEAR | writing zero to every word, one per cycle; no requests granted
// ST_RUN   | round-robin arbitration, one access issued per cycle
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear_req,
  output logic                  o_clear_busy,
  input  logic [1:0]            i_req_valid,
  input  logic [1:0]            i_req_we,
  input  logic [2*ADDR_W-1:0]   i_req_addr,
  input  logic [2*DATA_W-1:0]   i_req_wdata,
  output logic [1:0]            o_req_ready,
  output logic [1:0]            o_rsp_valid,
  output logic [DATA_W-1:0]     o_rsp_rdata,
  output logic                  o_ram_wr_en,
  output logic                  o_ram_rd_en,
  output logic [ADDR_W-1:0]     o_ram_addr,
  output logic [DATA_W-1:0]     o_ram_data_in,
  input  logic [DATA_W-1:0]     i_ram_data_out
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CLR_ONE  = (ADDR_W + 1)'(1);

  state_t              r_state, w_state_next;
  logic [ADDR_W:0]     r_clr_addr, w_clr_addr_next;
  logic                r_rr_ptr, w_ptr_next;
  logic [1:0]          w_grant;
  logic                w_arb_en;
  logic                w_sel;

  logic                r_ram_wr_en, r_ram_rd_en;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_data_in;
  logic                w_wr_next, w_rd_next;
  logic [ADDR_W-1:0]   w_addr_next;
  logic [DATA_W-1:0]   w_data_next;

  rsp_tag_t            r_tag1, r_tag2, w_tag_next;

  // A clear request in RUN blocks acceptance in that same cycle.
  assign w_arb_en = (r_state == ST_RUN) && !i_clear_req;
  assign w_sel    = w_grant[1];

  rr_arb2 u_arb (
    .i_valid    (i_req_valid),
    .i_en       (w_arb_en),
    .i_ptr      (r_rr_ptr),
    .o_grant    (w_grant),
    .o_ptr_next (w_ptr_next)
  );

  // Next-state, sweep address and next RAM command; nothing issued unless cleared or accepted.
  always_comb begin
    w_state_next    = r_state;
    w_clr_addr_next = r_clr_addr;
    w_wr_next       = 1'b0;
    w_rd_next       = 1'b0;
    w_addr_next     = r_ram_addr;
    w_data_next     = r_ram_data_in;
    w_tag_next      = '0;
    case (r_state)
      ST_CLEAR: begin
        w_wr_next       = 1'b1;
        w_addr_next     = r_clr_addr[ADDR_W-1:0];
        w_data_next     = '0;
        w_clr_addr_next = r_clr_addr + CLR_ONE;
        if (r_clr_addr == CLR_LAST) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_clear_req) begin
          w_state_next    = ST_CLEAR;
          w_clr_addr_next = '0;
        end else if (|w_grant) begin
          w_wr_next     = i_req_we[w_sel];
          w_rd_next     = ~i_req_we[w_sel];
          w_addr_next   = w_sel ? i_req_addr[2*ADDR_W-1:ADDR_W] : i_req_addr[ADDR_W-1:0];
          w_data_next   = w_sel ? i_req_wdata[2*DATA_W-1:DATA_W] : i_req_wdata[DATA_W-1:0];
          w_tag_next.id = w_sel;
          w_tag_next.rd = ~i_req_we[w_sel];
        end
      end
      default: begin
        w_state_next = ST_CLEAR;
      end
    endcase
  end

  // Controller state: FSM, sweep address and round-robin pointer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
      r_rr_ptr   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_clr_addr <= w_clr_addr_next;
      r_rr_ptr   <= w_ptr_next;
    end
  end

  // Registered RAM command; address and data hold when nothing is issued.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ram_wr_en   <= 1'b0;
      r_ram_rd_en   <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_data_in <= '0;
    end else begin
      r_ram_wr_en   <= w_wr_next;
      r_ram_rd_en   <= w_rd_next;
      r_ram_addr    <= w_addr_next;
      r_ram_data_in <= w_data_next;
    end
  end

  // Two-stage tag pipe matching command register plus RAM read register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tag1 <= '0;
      r_tag2 <= '0;
    end else begin
      r_tag1 <= w_tag_next;
      r_tag2 <= r_tag1;
    end
  end

  assign o_clear_busy  = (r_state == ST_CLEAR);
  assign o_req_ready   = w_grant;
  assign o_rsp_valid   = {r_tag2.rd & r_tag2.id, r_tag2.rd & ~r_tag2.id};
  assign o_rsp_rdata   = i_ram_data_out;
  assign o_ram_wr_en   = r_ram_wr_en;
  assign o_ram_rd_en   = r_ram_rd_en;
  assign o_ram_addr    = r_ram_addr;
  assign o_ram_data_in = r_ram_data_in;

endmodule
